// File: rtl/caracol_trilha_tx.sv
// caracol_trilha_tx: parallel-to-serial stimulus driver for the snail
// pattern detector. Words accepted over valid/ready are shifted MSB-first
// onto the 1-bit track x, each bit held for DIV cycles. An internal
// overlapping 1101/1110 Mealy model follows the emitted bits and produces
// the detector's expected output y_exp plus a saturating match counter.
module caracol_trilha_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             y_exp,
    output logic [CNT_W-1:0] match_count
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(DIV - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Pattern-model states, named after the matched prefix
    localparam logic [2:0] P0 = 3'd0;  // no prefix
    localparam logic [2:0] P1 = 3'd1;  // "1"
    localparam logic [2:0] P2 = 3'd2;  // "11"
    localparam logic [2:0] P3 = 3'd3;  // "110"
    localparam logic [2:0] P4 = 3'd4;  // "111"

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [BIT_W-1:0] bitcnt;
    logic [DIV_W-1:0] divcnt;
    logic [2:0]       pstate;
    logic [2:0]       pstate_nxt;
    logic             last_cycle;
    logic             accept;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Handshake and track outputs decoded straight from the control registers
    always_comb begin
        last_cycle = (state == SHIFT) && (bitcnt == LAST_BIT) && (divcnt == LAST_DIV);
        data_ready = (state == IDLE) || last_cycle;
        accept     = data_valid && data_ready;
        busy       = (state == SHIFT);
        x          = (state == SHIFT) && shreg[WIDTH-1];
        x_valid    = (state == SHIFT) && (divcnt == '0);
    end

    // Control FSM: load on handshake, hold each bit DIV cycles, advance MSB to LSB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            divcnt <= '0;
        end else if (accept) begin
            state  <= SHIFT;
            shreg  <= data_in;
            bitcnt <= '0;
            divcnt <= '0;
        end else if (state == SHIFT) begin
            if (divcnt == LAST_DIV) begin
                divcnt <= '0;
                if (bitcnt == LAST_BIT) begin
                    state  <= IDLE;
                    bitcnt <= '0;
                    shreg  <= '0;
                end else begin
                    bitcnt <= bitcnt + BIT_W'(1);
                    shreg  <= shreg << 1;
                end
            end else begin
                divcnt <= divcnt + DIV_W'(1);
            end
        end
    end

    // Overlapping 1101/1110 Mealy model; evaluated only on bit-start cycles
    always_comb begin
        pstate_nxt = pstate;
        y_exp      = 1'b0;
        if (x_valid) begin
            case (pstate)
                P0:      pstate_nxt = x ? P1 : P0;
                P1:      pstate_nxt = x ? P2 : P0;
                P2:      pstate_nxt = x ? P4 : P3;
                P3: begin
                    pstate_nxt = x ? P1 : P0;
                    y_exp      = x;
                end
                P4: begin
                    pstate_nxt = x ? P4 : P3;
                    y_exp      = !x;
                end
                default: pstate_nxt = P0;
            endcase
        end
    end

    // Pattern-model state register; history survives word gaps until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pstate <= P0;
        end else if (x_valid) begin
            pstate <= pstate_nxt;
        end
    end

    // Saturating count of matches emitted since reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_count <= '0;
        end else if (y_exp) begin
            match_count <= sat_inc(match_count);
        end
    end

endmodule

// File: tb/tb_caracol_trilha_tx.sv
// Testbench for caracol_trilha_tx. Three instances share clk/reset:
// dut (DIV=1, CNT_W=8) and dut_s (DIV=1, CNT_W=2) see identical inputs,
// dut_d (DIV=3) has its own inputs. Expected values come from a model that
// keeps the last four emitted bits and flags a match when the window reads
// 1101 or 1110.
module tb_caracol_trilha_tx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready, x, x_valid, busy, y_exp;
    logic [7:0] match_count;

    logic       s_ready, s_x, s_xv, s_busy, s_y;
    logic [1:0] s_count;

    logic [7:0] d_in;
    logic       d_valid;
    logic       d_ready, d_x, d_xv, d_busy, d_y;
    logic [7:0] d_count;

    int checks = 0;
    int fails  = 0;

    // reference model state
    logic [3:0] hist;
    int         mcount;
    logic [7:0] wq[8];

    caracol_trilha_tx #(.WIDTH(8), .DIV(1), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .x(x), .x_valid(x_valid), .busy(busy),
        .y_exp(y_exp), .match_count(match_count)
    );

    caracol_trilha_tx #(.WIDTH(8), .DIV(1), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(s_ready), .x(s_x), .x_valid(s_xv), .busy(s_busy),
        .y_exp(s_y), .match_count(s_count)
    );

    caracol_trilha_tx #(.WIDTH(8), .DIV(3), .CNT_W(8)) dut_d (
        .clk(clk), .reset(reset), .data_in(d_in), .data_valid(d_valid),
        .data_ready(d_ready), .x(d_x), .x_valid(d_xv), .busy(d_busy),
        .y_exp(d_y), .match_count(d_count)
    );

    function automatic logic [1:0] sat2(input int v);
        return (v > 3) ? 2'd3 : 2'(v);
    endfunction

    // Assert reset away from a clock edge, check outputs at once, release.
    task automatic test_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        data_valid = 1'b0; data_in = '0; d_valid = 1'b0; d_in = '0;
        #1;
        checks++; if ({x, x_valid, busy, y_exp} !== 4'b0000) begin fails++; $display("FAIL reset_outs x/xv/busy/y=%b want 0000", {x, x_valid, busy, y_exp}); end
        checks++; if (match_count !== 8'd0) begin fails++; $display("FAIL reset_count got %0d want 0", match_count); end
        checks++; if (data_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", data_ready); end
        checks++; if ({d_busy, d_ready, s_count} !== 4'b0100) begin fails++; $display("FAIL reset_other got %b want 0100", {d_busy, d_ready, s_count}); end
        @(negedge clk);
        reset = 1'b0;
        hist = 4'b0000;
        mcount = 0;
    endtask

    // Send wq[0..n-1] back-to-back on dut/dut_s, checking every cycle.
    task automatic send_words(input int n, input string tag);
        logic eb, ey;
        @(negedge clk);
        checks++; if (data_ready !== 1'b1) begin fails++; $display("FAIL %s idle_ready got %b want 1", tag, data_ready); end
        data_in = wq[0];
        data_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 8; b++) begin
                @(negedge clk);
                eb = wq[k][7-b];
                ey = ({hist[2:0], eb} == 4'b1101) || ({hist[2:0], eb} == 4'b1110);
                hist = {hist[2:0], eb};
                checks++; if (x !== eb) begin fails++; $display("FAIL %s x w%0d b%0d got %b want %b", tag, k, b, x, eb); end
                checks++; if ({x_valid, busy} !== 2'b11) begin fails++; $display("FAIL %s xv_busy w%0d b%0d got %b want 11", tag, k, b, {x_valid, busy}); end
                checks++; if (data_ready !== (b == 7)) begin fails++; $display("FAIL %s ready w%0d b%0d got %b want %b", tag, k, b, data_ready, (b == 7)); end
                checks++; if (y_exp !== ey) begin fails++; $display("FAIL %s y_exp w%0d b%0d got %b want %b", tag, k, b, y_exp, ey); end
                checks++; if (match_count !== 8'(mcount)) begin fails++; $display("FAIL %s count w%0d b%0d got %0d want %0d", tag, k, b, match_count, mcount); end
                checks++; if ({s_y, s_count} !== {ey, sat2(mcount)}) begin fails++; $display("FAIL %s sat w%0d b%0d got %b want %b", tag, k, b, {s_y, s_count}, {ey, sat2(mcount)}); end
                if (ey) mcount++;
                if (b == 7) begin
                    if (k + 1 < n) data_in = wq[k+1];
                    else data_valid = 1'b0;
                end else begin
                    data_in = 8'($urandom);
                end
            end
        end
        @(negedge clk);
        checks++; if ({busy, x, x_valid, y_exp, data_ready} !== 5'b00001) begin fails++; $display("FAIL %s end_idle busy/x/xv/y/rdy=%b want 00001", tag, {busy, x, x_valid, y_exp, data_ready}); end
        checks++; if (match_count !== 8'(mcount)) begin fails++; $display("FAIL %s end_count got %0d want %0d", tag, match_count, mcount); end
        checks++; if (s_count !== sat2(mcount)) begin fails++; $display("FAIL %s end_sat got %0d want %0d", tag, s_count, sat2(mcount)); end
    endtask

    task automatic test_single_word();
        test_reset();
        wq[0] = 8'b1101_1100;
        send_words(1, "single");
        checks++; if (match_count !== 8'd2) begin fails++; $display("FAIL single_total got %0d want 2", match_count); end
    endtask

    task automatic test_back_to_back();
        test_reset();
        wq[0] = 8'h03; wq[1] = 8'h40;
        send_words(2, "b2b");
        checks++; if (match_count !== 8'd1) begin fails++; $display("FAIL b2b_total got %0d want 1", match_count); end
    endtask

    task automatic test_boundary_1110();
        test_reset();
        wq[0] = 8'hFF; wq[1] = 8'h00;
        send_words(2, "b1110");
        checks++; if (match_count !== 8'd1) begin fails++; $display("FAIL b1110_total got %0d want 1", match_count); end
    endtask

    task automatic test_saturation();
        test_reset();
        wq[0] = 8'b1101_1101;
        send_words(1, "sat1");
        checks++; if (s_count !== 2'd3) begin fails++; $display("FAIL sat_word1 got %0d want 3", s_count); end
        test_reset();
        wq[0] = 8'b1101_1101; wq[1] = 8'b1101_1101;
        send_words(2, "sat2");
        checks++; if (s_count !== 2'd3) begin fails++; $display("FAIL sat_hold got %0d want 3", s_count); end
    endtask

    // Random words and bursts with idle gaps; history must persist across gaps.
    task automatic test_random();
        int n;
        test_reset();
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wq[i] = 8'($urandom);
            send_words(n, "rand");
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                checks++; if ({y_exp, x_valid, busy} !== 3'b000) begin fails++; $display("FAIL rand_gap y/xv/busy=%b want 000", {y_exp, x_valid, busy}); end
            end
        end
    endtask

    task automatic test_div3();
        logic eb;
        test_reset();
        @(negedge clk);
        checks++; if (d_ready !== 1'b1) begin fails++; $display("FAIL div3_ready0 got %b want 1", d_ready); end
        d_in = 8'hA5;
        d_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            eb = 1'(8'hA5 >> (7 - c / 3));
            checks++; if (d_x !== eb) begin fails++; $display("FAIL div3_x c%0d got %b want %b", c, d_x, eb); end
            checks++; if (d_xv !== (c % 3 == 0)) begin fails++; $display("FAIL div3_xv c%0d got %b want %b", c, d_xv, (c % 3 == 0)); end
            checks++; if ({d_busy, d_ready, d_y} !== {1'b1, (c == 23), 1'b0}) begin fails++; $display("FAIL div3_ctl c%0d got %b want %b", c, {d_busy, d_ready, d_y}, {1'b1, (c == 23), 1'b0}); end
            d_valid = (c < 23);
            d_in = 8'($urandom);
        end
        @(negedge clk);
        checks++; if ({d_busy, d_x, d_xv, d_ready} !== 4'b0001) begin fails++; $display("FAIL div3_end busy/x/xv/rdy=%b want 0001", {d_busy, d_x, d_xv, d_ready}); end
        checks++; if (d_count !== 8'd0) begin fails++; $display("FAIL div3_count got %0d want 0", d_count); end
    endtask

    task automatic test_reset_midword();
        test_reset();
        @(negedge clk);
        data_in = 8'hE0;
        data_valid = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            checks++; if (x !== 1'b1) begin fails++; $display("FAIL mid_x b%0d got %b want 1", b, x); end
            data_valid = 1'b0;
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if ({x, x_valid, busy, y_exp} !== 4'b0000) begin fails++; $display("FAIL mid_rst outs=%b want 0000", {x, x_valid, busy, y_exp}); end
        checks++; if ({match_count, data_ready} !== {8'd0, 1'b1}) begin fails++; $display("FAIL mid_rst cnt/rdy got %0d/%b want 0/1", match_count, data_ready); end
        @(negedge clk);
        reset = 1'b0;
        hist = 4'b0000;
        mcount = 0;
        @(negedge clk);
        checks++; if ({busy, x_valid} !== 2'b00) begin fails++; $display("FAIL mid_release busy/xv=%b want 00", {busy, x_valid}); end
        wq[0] = 8'b0110_1000;
        send_words(1, "fresh");
        checks++; if (match_count !== 8'd1) begin fails++; $display("FAIL fresh_total got %0d want 1", match_count); end
    endtask

    initial begin
        reset = 1'b0;
        data_in = '0; data_valid = 1'b0;
        d_in = '0; d_valid = 1'b0;
        hist = 4'b0000;
        mcount = 0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_boundary_1110();
        test_saturation();
        test_div3();
        test_reset_midword();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
